// File: rtl/stream_demultiplexer_n_pkg.sv
// Shared constants for the 1:4 stream demultiplexer.
// Provides channel count, select width, default data width and channel codes.
package stream_demultiplexer_n_pkg;

  localparam int NUM_CH          = 4;
  localparam int NUM_OF_SEL_BITS = 2;
  localparam int DEF_WIDTH       = 16;

  localparam logic [NUM_OF_SEL_BITS-1:0] CH_OUT1 = 2'd0;
  localparam logic [NUM_OF_SEL_BITS-1:0] CH_OUT2 = 2'd1;
  localparam logic [NUM_OF_SEL_BITS-1:0] CH_OUT3 = 2'd2;
  localparam logic [NUM_OF_SEL_BITS-1:0] CH_OUT4 = 2'd3;

endpackage

// File: rtl/stream_demultiplexer_n_demux_slot.sv
// Single-entry holding register for one output channel.
// Ports: CLK, RST, i_load, i_data, i_ready -> o_data, o_valid.
module demux_slot
  import stream_demultiplexer_n_pkg::*;
#(
  parameter int INPUT_WIDTH = DEF_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_load,
  input  logic [INPUT_WIDTH-1:0] i_data,
  input  logic                   i_ready,
  output logic [INPUT_WIDTH-1:0] o_data,
  output logic                   o_valid
);

  logic [INPUT_WIDTH-1:0] r_data;
  logic                   r_valid;

  // A load wins over a drain so a same-cycle refill leaves no bubble.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/stream_demultiplexer_n.sv
// 1:4 valid/ready stream demultiplexer, explicit select or round-robin.
// Ports: CLK, RST, IN/IN_VALID/IN_READY, SEL, AUTO, OUT1..4, OUT_VALID, OUT_READY, CUR_SEL.
module stream_demultiplexer_n
  import stream_demultiplexer_n_pkg::*;
#(
  parameter int INPUT_WIDTH     = DEF_WIDTH,
  parameter int NUM_OF_SEL_BITS = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [INPUT_WIDTH-1:0]     IN,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [NUM_OF_SEL_BITS-1:0] SEL,
  input  logic                       AUTO,
  output logic [INPUT_WIDTH-1:0]     OUT1,
  output logic [INPUT_WIDTH-1:0]     OUT2,
  output logic [INPUT_WIDTH-1:0]     OUT3,
  output logic [INPUT_WIDTH-1:0]     OUT4,
  output logic [NUM_CH-1:0]          OUT_VALID,
  input  logic [NUM_CH-1:0]          OUT_READY,
  output logic [NUM_OF_SEL_BITS-1:0] CUR_SEL
);

  logic [NUM_OF_SEL_BITS-1:0] r_rr_ptr;
  logic [NUM_OF_SEL_BITS-1:0] w_tgt;
  logic                       w_acc;
  logic [NUM_CH-1:0]          w_load;
  logic [INPUT_WIDTH-1:0]     w_out [NUM_CH];

  // During reset the pointer may still hold a stale value for this cycle.
  assign w_tgt = AUTO ? (RST ? '0 : r_rr_ptr) : SEL;
  assign CUR_SEL = w_tgt;

  assign IN_READY = RST | ~OUT_VALID[w_tgt] | OUT_READY[w_tgt];
  assign w_acc    = IN_VALID & IN_READY & ~RST;

  always_comb begin
    w_load = '0;
    w_load[w_tgt] = w_acc;
  end

  // Pointer parks at 0 outside auto mode so each auto entry starts at OUT1.
  always_ff @(posedge CLK) begin
    if (RST || !AUTO) begin
      r_rr_ptr <= '0;
    end else if (w_acc) begin
      r_rr_ptr <= r_rr_ptr + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(
      .INPUT_WIDTH(INPUT_WIDTH)
    ) u_slot (
      .CLK    (CLK),
      .RST    (RST),
      .i_load (w_load[k]),
      .i_data (IN),
      .i_ready(OUT_READY[k]),
      .o_data (w_out[k]),
      .o_valid(OUT_VALID[k])
    );
  end

  assign OUT1 = w_out[0];
  assign OUT2 = w_out[1];
  assign OUT3 = w_out[2];
  assign OUT4 = w_out[3];

endmodule

// File: doc/stream_demultiplexer_n.md
# stream_demultiplexer_n

Routes one valid/ready input stream to one of four registered output channels, either by the explicit select or automatically in round-robin order (de-interleave mode). It sits where one sample stream fans out to four consumers in the DSP controller datapath. It is the counterpart of the 4:1 input multiplexer. Each output has a single-entry holding register, so consumers may stall independently without corrupting other channels.

## Interface
- INPUT_WIDTH, 16: data width of input and every output.
- NUM_OF_SEL_BITS, 2: select width; fixed at 2 for four channels.
---
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- IN  input  INPUT_WIDTH  input sample.
- IN_VALID  input  1  IN holds a sample.
- IN_READY  output  1  block accepts IN this cycle.
- SEL  input  NUM_OF_SEL_BITS  target channel when AUTO=0: 0→OUT1, 1→OUT2, 2→OUT3, 3→OUT4.
- AUTO  input  1  1 = round-robin de-interleave; SEL ignored.
- OUT1..OUT4  output  INPUT_WIDTH each  channel data registers.
- OUT_VALID  output  4  bit k-1 = OUTk holds an undelivered sample.
- OUT_READY  input  4  bit k-1 = consumer k takes OUTk this cycle.
- CUR_SEL  output  NUM_OF_SEL_BITS  channel targeted this cycle (SEL or round-robin pointer).

## Operation
- Target t = AUTO ? rr_ptr : SEL; CUR_SEL = t (combinational).
- IN_READY = !OUT_VALID[t] | OUT_READY[t]. Never depends on IN_VALID.
- Accept = IN_VALID & IN_READY. On accept: OUT(t+1) <= IN, OUT_VALID[t] <= 1.
- Drain: OUT_VALID[k] & OUT_READY[k] clears OUT_VALID[k] next cycle unless the same channel is loaded that cycle.
- Simultaneous drain and load on one channel: OUT_VALID stays 1; data becomes the new sample. No bubble.
- OUTk data is not cleared on drain; it holds the last value. Meaningful only while OUT_VALID[k]=1.
- Round-robin pointer rr_ptr (2 bits): increments on each accept while AUTO=1, wraps 3→0. Held at 0 whenever AUTO=0, so every entry into auto mode starts at OUT1.
- A stalled target channel in auto mode blocks the input. The pointer never skips a full channel. Sample order per channel is preserved.
- Non-target channels drain independently of input activity.
- SEL or AUTO may change any cycle; they take effect on that cycle's target. Held channel contents are unaffected.

## Timing
- Reset, checked at the CLK edge with RST=1: OUT_VALID=4'b0000, OUT1..OUT4=0, rr_ptr=0. RST overrides any accept or drain that cycle.
- While RST=1: IN_READY=1 and CUR_SEL=SEL (AUTO=0) or 0 (AUTO=1). No state changes.
- Latency: a sample accepted at edge n appears with OUT_VALID=1 after edge n. One cycle.
- Throughput: one sample per cycle sustained when the target consumer holds OUT_READY=1.
- Combinational paths: OUT_READY→IN_READY and SEL/AUTO→IN_READY, CUR_SEL. Upstream must not make IN_VALID depend on IN_READY.
- Reset mid-stream discards all held samples; the pointer returns to 0.

## Structure
- Shared package: channel count (4), NUM_OF_SEL_BITS, default INPUT_WIDTH, channel index encodings 0..3.
- Sub-module demux_slot: one per channel (instantiated ×4).
  - Inputs: load, data, OUT_READY.
  - Outputs: data register and valid flag.
  - Implements the load/drain/simultaneous rules.
- Top level holds rr_ptr, target decode, IN_READY and CUR_SEL.

## Test plan
- Reset: assert RST 2 cycles with IN_VALID=1 → OUT_VALID=0000, OUT1..4=0, no load. After release, IN=16'h1234, SEL=2 → OUT3=16'h1234, OUT_VALID=0100 one cycle later.
- Backpressure: OUT_READY=0000, SEL=0, send 16'hAAAA then 16'hBBBB.
  - Expected: first accepted, IN_READY=0 on the second; OUT1 holds 16'hAAAA.
  - Raise OUT_READY[0] → 16'hBBBB accepted in the same cycle, OUT_VALID[0] stays 1.
- Auto de-interleave: AUTO=1, all OUT_READY=1, stream 1..8 → OUT1 sees 1,5; OUT2 2,6; OUT3 3,7; OUT4 4,8. CUR_SEL cycles 0,1,2,3,0.
- Auto stall: AUTO=1, OUT_READY[2]=0 with OUT3 full → input blocked at the 3rd sample, rr_ptr stays 2; release → resumes at OUT3, no skip.
- Mode switch: AUTO 1→0 mid-stream with rr_ptr=3, then 0→1 → subsequent auto samples start at OUT1; held OUTk data unchanged.
- Reset mid-operation: all four channels full, assert RST → OUT_VALID=0000 next edge; rr_ptr=0.
